// File: rtl/md_pkg.sv
// md_pkg: shared opcode/funct encodings and default latencies
// for the multiply/divide hazard controller.
package md_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/md_hazard_ctrl_if.sv
// md_hazard_ctrl_if: pipeline <-> hazard controller bundle.
// master = pipeline side (drives instrs/busy), slave = controller.
interface md_hazard_ctrl_if;

  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic        md_busy;
  logic        md_start;
  logic        stall_d;
  logic        md_pending;

  modport master (
    output instr_d,
    output instr_e,
    output md_busy,
    input  md_start,
    input  stall_d,
    input  md_pending
  );

  modport slave (
    input  instr_d,
    input  instr_e,
    input  md_busy,
    output md_start,
    output stall_d,
    output md_pending
  );

endinterface

// File: rtl/md_class.sv
// md_class: combinational decode of one instruction.
// in: instr[31:0]; out: is_md, is_hilo, is_div.
module md_class
  import md_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic        is_hilo,
  output logic        is_div
);

  logic       special;
  logic [5:0] fn;
  logic       mv;
  logic       unused_bits;

  assign special = (instr[31:26] == OP_SPECIAL);
  assign fn      = instr[5:0];

  always_comb begin
    is_md  = 1'b0;
    is_div = 1'b0;
    mv     = 1'b0;
    if (special) begin
      unique case (fn)
        FN_MULT, FN_MULTU: is_md = 1'b1;
        FN_DIV, FN_DIVU: begin
          is_md  = 1'b1;
          is_div = 1'b1;
        end
        FN_MFHI, FN_MTHI,
        FN_MFLO, FN_MTLO: mv = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_hilo = is_md | mv;

  assign unused_bits = ^instr[25:6];

endmodule

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: HI/LO hazard stall, shadow latency counter
// and stall statistics. Optional checker: define MD_CHECK_EN.
// Ports: clk, reset (sync, active-high), bus (slave modport),
// stall_cycles[31:0] (saturating), md_err (sticky, or 0).
module md_hazard_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  md_hazard_ctrl_if.slave   bus,
  output logic [31:0]       stall_cycles,
  output logic              md_err
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

  logic md_d, hilo_d, div_d;
  logic md_e, hilo_e, div_e;
  logic unused_cls;

  md_class u_class_d (
    .instr   (bus.instr_d),
    .is_md   (md_d),
    .is_hilo (hilo_d),
    .is_div  (div_d)
  );

  md_class u_class_e (
    .instr   (bus.instr_e),
    .is_md   (md_e),
    .is_hilo (hilo_e),
    .is_div  (div_e)
  );

  assign unused_cls = md_d ^ div_d ^ hilo_e;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      stall_cnt;
  logic             pend;
  logic             stall;

  assign pend  = (cnt != '0);
  // busy is ORed in so a unit slower than MUL/DIV_CYCLES stays safe
  assign stall = hilo_d & (md_e | pend | bus.md_busy);

  assign bus.md_start   = md_e;
  assign bus.md_pending = pend;
  assign bus.stall_d    = stall;
  assign stall_cycles   = stall_cnt;

  // a new op reloads even if one is still counting (last wins)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (md_e) begin
      cnt <= div_e ? DIV_LD : MUL_LD;
    end else if (pend) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

`ifdef MD_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((!md_e && (bus.md_busy != pend))
                 || (md_e && pend)) begin
      err_q <= 1'b1;
    end
  end

  assign md_err = err_q;
`else
  assign md_err = 1'b0;
`endif

endmodule
